// File: rtl/nbload_tracker_pkg.sv
// Shared types and helpers for the non-blocking load tracker.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: per-entry lifecycle state enum and the event-legality helpers
// used by the tracker. The per-entry record (state, kill, rd, data) is
// declared in the top module because its data field follows DATA_W.
package nbload_tracker_pkg;

    // Entry lifecycle:
    //   NB_IDLE   free
    //   NB_PEND   allocated, neither committed nor returned
    //   NB_COMMIT committed, waiting for data
    //   NB_EARLY  data held, not yet committed
    //   NB_READY  committed with data, waiting for the write port
    typedef enum logic [2:0] {
        NB_IDLE   = 3'd0,
        NB_PEND   = 3'd1,
        NB_COMMIT = 3'd2,
        NB_EARLY  = 3'd3,
        NB_READY  = 3'd4
    } nbload_state_t;

    // A commit is meaningful only for an entry that has not committed yet.
    function automatic logic commit_legal(input nbload_state_t s);
        return (s == NB_PEND) || (s == NB_EARLY);
    endfunction

    // A data return is meaningful only for an entry still missing its data.
    function automatic logic ret_legal(input nbload_state_t s);
        return (s == NB_PEND) || (s == NB_COMMIT);
    endfunction

    // A younger write to the same rd only matters once the load is known
    // to be architecturally real (committed) or already holds data.
    function automatic logic kill_applies(input nbload_state_t s);
        return (s == NB_COMMIT) || (s == NB_EARLY) || (s == NB_READY);
    endfunction

endpackage

// File: rtl/nbload_tracker_if.sv
// Bundles the LSU-side, decode-side and GPR-write-side signals of the tracker.
// Latency: n/a (wiring only).
// Backpressure: alloc_ready gates allocation; no other stalls.
//
// master: the pipeline (LSU/decode/GPR) side; slave: the tracker itself.
// Signals: alloc_valid/alloc_rd/alloc_ready/alloc_tag, commit_valid/commit_tag,
// flush, kill_valid/kill_rd, ret_valid/ret_tag/ret_data, lookup_rs/lookup_hit,
// nb_wen/nb_waddr/nb_wdata, proto_err, busy.
interface nbload_tracker_if #(
    parameter int DEPTH      = 4,
    parameter int NUM_LOOKUP = 4,
    parameter int DATA_W     = 32
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                    alloc_valid;
    logic [4:0]              alloc_rd;
    logic                    alloc_ready;
    logic [TAG_W-1:0]        alloc_tag;
    logic                    commit_valid;
    logic [TAG_W-1:0]        commit_tag;
    logic                    flush;
    logic                    kill_valid;
    logic [4:0]              kill_rd;
    logic                    ret_valid;
    logic [TAG_W-1:0]        ret_tag;
    logic [DATA_W-1:0]       ret_data;
    logic [NUM_LOOKUP*5-1:0] lookup_rs;
    logic [NUM_LOOKUP-1:0]   lookup_hit;
    logic                    nb_wen;
    logic [4:0]              nb_waddr;
    logic [DATA_W-1:0]       nb_wdata;
    logic                    proto_err;
    logic                    busy;

    modport master (
        output alloc_valid, alloc_rd, commit_valid, commit_tag, flush,
               kill_valid, kill_rd, ret_valid, ret_tag, ret_data, lookup_rs,
        input  alloc_ready, alloc_tag, lookup_hit, nb_wen, nb_waddr, nb_wdata,
               proto_err, busy
    );

    modport slave (
        input  alloc_valid, alloc_rd, commit_valid, commit_tag, flush,
               kill_valid, kill_rd, ret_valid, ret_tag, ret_data, lookup_rs,
        output alloc_ready, alloc_tag, lookup_hit, nb_wen, nb_waddr, nb_wdata,
               proto_err, busy
    );

endinterface

// File: rtl/nbload_tracker_prio_enc.sv
// Lowest-index priority encoder (free-entry pick and writeback pick).
// Latency: combinational.
// Backpressure: none.
//
// Ports: req_i  request vector
//        vld_o  any request set
//        idx_o  index of lowest set request, 0 when none
module nbload_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        // Scan from the top so the lowest set bit is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nbload_tracker.sv
// Tracks outstanding non-blocking loads and writes their data to the GPR file.
// Latency: ret on a committed entry -> nb_wen next cycle (same cycle with bypass).
// Backpressure: alloc_ready low when all entries busy; losing READY entries wait.
//
// Optional build macro: RV_NBLOAD_RET_BYPASS_EN -- a return to a committed,
// unkilled entry writes the GPR in the same cycle and frees the entry.
//
// Ports: clk, rst (synchronous, active-high), bus (nbload_tracker_if.slave):
//   allocation (alloc_*), commit (commit_*), flush, kill (kill_*),
//   data return (ret_*), decode hazard lookup (lookup_rs/lookup_hit),
//   GPR write (nb_wen/nb_waddr/nb_wdata), proto_err pulse, busy.
module nbload_tracker #(
    parameter int DEPTH      = 4,
    parameter int NUM_LOOKUP = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    nbload_tracker_if.slave  bus
);
    import nbload_tracker_pkg::*;

    typedef struct packed {
        nbload_state_t     state;
        logic              kill;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } nbload_entry_t;

    nbload_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic                      err_q, err_d;

    logic [DEPTH-1:0]      idle_vec;
    logic [DEPTH-1:0]      wb_req_vec;
    logic [DEPTH-1:0]      alloc_sel, commit_sel, ret_sel, kill_sel, wb_take;
    logic                  free_vld, wb_vld;
    logic [TAG_W-1:0]      free_idx, wb_idx;
    logic                  alloc_fire, commit_ok, ret_ok, byp;
    logic [4:0]            byp_rd;
    logic                  wen;
    logic [4:0]            waddr;
    logic [DATA_W-1:0]     wdata;
    logic [NUM_LOOKUP-1:0] hit;

    // ------------------------------------------------------------------
    // Entry selection
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            idle_vec[i]   = (ent_q[i].state == NB_IDLE);
            wb_req_vec[i] = (ent_q[i].state == NB_READY) && !ent_q[i].kill;
        end
    end

    nbload_prio_enc #(.N(DEPTH), .IDX_W(TAG_W)) u_free_sel (
        .req_i (idle_vec),
        .vld_o (free_vld),
        .idx_o (free_idx)
    );

    nbload_prio_enc #(.N(DEPTH), .IDX_W(TAG_W)) u_wb_sel (
        .req_i (wb_req_vec),
        .vld_o (wb_vld),
        .idx_o (wb_idx)
    );

    // ------------------------------------------------------------------
    // Event decode (legality judged on the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        alloc_fire = bus.alloc_valid && free_vld;
        commit_ok  = bus.commit_valid && commit_legal(ent_q[bus.commit_tag].state);
        ret_ok     = bus.ret_valid && ret_legal(ent_q[bus.ret_tag].state);
`ifdef RV_NBLOAD_RET_BYPASS_EN
        byp        = bus.ret_valid && (ent_q[bus.ret_tag].state == NB_COMMIT)
                     && !ent_q[bus.ret_tag].kill;
`else
        byp        = 1'b0;
`endif
        byp_rd     = ent_q[bus.ret_tag].rd;

        // Offending events are dropped; only the flag records them.
        err_d = (bus.commit_valid && !commit_ok)
              || (bus.ret_valid && !ret_ok)
              || (bus.alloc_valid && !free_vld);

        for (int i = 0; i < DEPTH; i++) begin
            alloc_sel[i]  = alloc_fire && (free_idx == TAG_W'(i));
            commit_sel[i] = commit_ok && (bus.commit_tag == TAG_W'(i));
            ret_sel[i]    = ret_ok && (bus.ret_tag == TAG_W'(i));
            kill_sel[i]   = bus.kill_valid && (ent_q[i].rd == bus.kill_rd)
                            && kill_applies(ent_q[i].state);
            // The bypassed return owns the write port; READY entries wait.
            wb_take[i]    = wb_vld && !byp && (wb_idx == TAG_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].state <= NB_IDLE;
                ent_q[i].kill  <= 1'b0;
                ent_q[i].rd    <= 5'd0;
                ent_q[i].data  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            case (ent_q[i].state)
                NB_IDLE: begin
                    if (alloc_sel[i]) begin
                        ent_d[i].state = NB_PEND;
                        ent_d[i].rd    = bus.alloc_rd;
                        ent_d[i].kill  = 1'b0;
                    end
                end
                NB_PEND: begin
                    // Commit together with data completes even under flush:
                    // the load is architecturally done before the flush lands.
                    if (commit_sel[i] && ret_sel[i]) begin
                        ent_d[i].state = NB_READY;
                        ent_d[i].data  = bus.ret_data;
                    end else if (bus.flush) begin
                        ent_d[i].state = NB_IDLE;
                    end else if (commit_sel[i]) begin
                        ent_d[i].state = NB_COMMIT;
                    end else if (ret_sel[i]) begin
                        ent_d[i].state = NB_EARLY;
                        ent_d[i].data  = bus.ret_data;
                    end
                end
                NB_COMMIT: begin
                    if (ret_sel[i]) begin
                        if (byp) begin
                            ent_d[i].state = NB_IDLE;
                        end else begin
                            ent_d[i].state = NB_READY;
                            ent_d[i].data  = bus.ret_data;
                        end
                    end
                end
                NB_EARLY: begin
                    if (bus.flush) begin
                        ent_d[i].state = NB_IDLE;
                    end else if (commit_sel[i]) begin
                        ent_d[i].state = NB_READY;
                    end
                end
                NB_READY: begin
                    // Killed entries drain silently alongside the winner.
                    if (ent_q[i].kill || wb_take[i]) begin
                        ent_d[i].state = NB_IDLE;
                    end
                end
                default: begin
                    ent_d[i].state = NB_IDLE;
                end
            endcase
            if (kill_sel[i]) begin
                ent_d[i].kill = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        wen   = 1'b0;
        waddr = 5'd0;
        wdata = '0;
        if (byp) begin
            wen   = 1'b1;
            waddr = byp_rd;
            wdata = bus.ret_data;
        end else if (wb_vld) begin
            wen   = 1'b1;
            waddr = ent_q[wb_idx].rd;
            wdata = ent_q[wb_idx].data;
        end

        hit = '0;
        for (int p = 0; p < NUM_LOOKUP; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((ent_q[i].state != NB_IDLE) && !ent_q[i].kill
                    && (ent_q[i].rd == bus.lookup_rs[p*5 +: 5])) begin
                    hit[p] = 1'b1;
                end
            end
            // x0 never carries a hazard; a bypassed rd is written this cycle.
            if ((bus.lookup_rs[p*5 +: 5] == 5'd0)
                || (byp && (bus.lookup_rs[p*5 +: 5] == byp_rd))) begin
                hit[p] = 1'b0;
            end
        end
    end

    assign bus.alloc_ready = free_vld;
    assign bus.alloc_tag   = free_idx;
    assign bus.lookup_hit  = hit;
    assign bus.nb_wen      = wen;
    assign bus.nb_waddr    = waddr;
    assign bus.nb_wdata    = wdata;
    assign bus.proto_err   = err_q;
    assign bus.busy        = ~&idle_vec;

endmodule

// File: tb/tb_nbload_tracker.sv
// Self-checking bench for nbload_tracker: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_nbload_tracker;

    localparam int DEPTH = 4;
    localparam int NL    = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;

    nbload_tracker_if #(.DEPTH(DEPTH), .NUM_LOOKUP(NL), .DATA_W(DW)) bus ();

    nbload_tracker #(.DEPTH(DEPTH), .NUM_LOOKUP(NL), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each load is described by flags, not by a state code.
    bit         m_on = 1'b0;
    bit         m_live [DEPTH];
    bit         m_comm [DEPTH];
    bit         m_hasd [DEPTH];
    bit         m_kil  [DEPTH];
    logic [4:0] m_rd   [DEPTH];
    logic [31:0] m_dat [DEPTH];
    bit         m_err;

    bit          e_ready, e_busy, e_byp, e_wen;
    int          e_tag, e_wb;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_hit;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void compute_exp();
        int rt;
        logic [4:0] rs;
        rt = int'(bus.ret_tag);
        e_ready = 1'b0; e_tag = 0; e_busy = 1'b0; e_byp = 1'b0; e_wb = -1;
        for (int t = DEPTH - 1; t >= 0; t--) begin
            if (!m_live[t]) begin
                e_ready = 1'b1;
                e_tag   = t;
            end else begin
                e_busy = 1'b1;
            end
            if (m_live[t] && m_comm[t] && m_hasd[t] && !m_kil[t]) e_wb = t;
        end
`ifdef RV_NBLOAD_RET_BYPASS_EN
        e_byp = bus.ret_valid && m_live[rt] && m_comm[rt] && !m_hasd[rt] && !m_kil[rt];
`endif
        if (e_byp) e_wb = -1;
        e_wen = e_byp || (e_wb >= 0);
        e_waddr = 5'd0;
        e_wdata = 32'd0;
        if (e_byp) begin
            e_waddr = m_rd[rt];
            e_wdata = bus.ret_data;
        end else if (e_wb >= 0) begin
            e_waddr = m_rd[e_wb];
            e_wdata = m_dat[e_wb];
        end
        for (int p = 0; p < NL; p++) begin
            rs = bus.lookup_rs[p*5 +: 5];
            e_hit[p] = 1'b0;
            if (rs != 5'd0) begin
                for (int t = 0; t < DEPTH; t++)
                    if (m_live[t] && !m_kil[t] && m_rd[t] == rs) e_hit[p] = 1'b1;
            end
            if (e_byp && rs == m_rd[rt]) e_hit[p] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit o_live [DEPTH];
        bit o_comm [DEPTH];
        bit o_hasd [DEPTH];
        bit o_kil  [DEPTH];
        logic [4:0] o_rd [DEPTH];
        int ct, rt;
        bit c_ok, r_ok, err, c, r;
        compute_exp();
        o_live = m_live; o_comm = m_comm; o_hasd = m_hasd; o_kil = m_kil; o_rd = m_rd;
        ct = int'(bus.commit_tag);
        rt = int'(bus.ret_tag);
        c_ok = bus.commit_valid && o_live[ct] && !o_comm[ct];
        r_ok = bus.ret_valid && o_live[rt] && !o_hasd[rt];
        err  = (bus.commit_valid && !c_ok) || (bus.ret_valid && !r_ok)
             || (bus.alloc_valid && !e_ready);
        for (int t = 0; t < DEPTH; t++) begin
            if (o_live[t]) begin
                c = c_ok && (ct == t);
                r = r_ok && (rt == t);
                if (c && r) begin
                    m_comm[t] = 1'b1; m_hasd[t] = 1'b1; m_dat[t] = bus.ret_data;
                end else if (bus.flush && !o_comm[t]) begin
                    m_live[t] = 1'b0;
                end else begin
                    if (c) m_comm[t] = 1'b1;
                    if (r) begin m_hasd[t] = 1'b1; m_dat[t] = bus.ret_data; end
                end
                if (e_byp && rt == t) m_live[t] = 1'b0;
                if (o_comm[t] && o_hasd[t] && (o_kil[t] || e_wb == t)) m_live[t] = 1'b0;
                if (bus.kill_valid && o_rd[t] == bus.kill_rd && (o_comm[t] || o_hasd[t]))
                    m_kil[t] = 1'b1;
            end
        end
        if (bus.alloc_valid && e_ready) begin
            m_live[e_tag] = 1'b1; m_comm[e_tag] = 1'b0; m_hasd[e_tag] = 1'b0;
            m_kil[e_tag] = 1'b0;  m_rd[e_tag] = bus.alloc_rd;
        end
        m_err = err;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < DEPTH; t++) begin
                m_live[t] = 1'b0; m_comm[t] = 1'b0; m_hasd[t] = 1'b0; m_kil[t] = 1'b0;
                m_rd[t] = 5'd0; m_dat[t] = 32'd0;
            end
            m_err = 1'b0;
            m_on  = 1'b1;
        end else if (m_on) begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            compute_exp();
            chk("alloc_ready", 64'(bus.alloc_ready), 64'(e_ready));
            chk("alloc_tag",   64'(bus.alloc_tag),   64'(e_tag));
            chk("busy",        64'(bus.busy),        64'(e_busy));
            chk("nb_wen",      64'(bus.nb_wen),      64'(e_wen));
            chk("nb_waddr",    64'(bus.nb_waddr),    64'(e_waddr));
            chk("nb_wdata",    64'(bus.nb_wdata),    64'(e_wdata));
            chk("lookup_hit",  64'(bus.lookup_hit),  64'(e_hit));
            chk("proto_err",   64'(bus.proto_err),   64'(m_err));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input bit av, input logic [4:0] ard, input bit cv, input logic [1:0] ct,
                         input bit rv, input logic [1:0] rt, input logic [31:0] rdat,
                         input bit fl, input bit kv, input logic [4:0] krd);
        bus.alloc_valid = av;  bus.alloc_rd = ard;
        bus.commit_valid = cv; bus.commit_tag = ct;
        bus.ret_valid = rv;    bus.ret_tag = rt; bus.ret_data = rdat;
        bus.flush = fl;        bus.kill_valid = kv; bus.kill_rd = krd;
    endtask

    task automatic d_idle();                 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic d_alloc(input logic [4:0] rd); drive(1, rd, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic d_commit(input logic [1:0] t); drive(0, 0, 1, t, 0, 0, 0, 0, 0, 0); endtask
    task automatic d_ret(input logic [1:0] t, input logic [31:0] d); drive(0, 0, 0, 0, 1, t, d, 0, 0, 0); endtask
    task automatic d_cr(input logic [1:0] ct, input logic [1:0] rt, input logic [31:0] d);
        drive(0, 0, 1, ct, 1, rt, d, 0, 0, 0);
    endtask
    task automatic d_flush();                drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic d_kill(input logic [4:0] rd); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, rd); endtask
    task automatic step(); @(posedge clk); #1; endtask

    task automatic rand_inputs();
        bus.flush        = ($urandom_range(0, 99) < 3);
        bus.alloc_valid  = !bus.flush && ($urandom_range(0, 99) < 40);
        bus.alloc_rd     = 5'($urandom_range(0, 7));
        bus.commit_valid = ($urandom_range(0, 99) < 45);
        bus.commit_tag   = 2'($urandom_range(0, 3));
        bus.ret_valid    = ($urandom_range(0, 99) < 45);
        bus.ret_tag      = 2'($urandom_range(0, 3));
        bus.ret_data     = $urandom;
        bus.kill_valid   = ($urandom_range(0, 99) < 10);
        bus.kill_rd      = 5'($urandom_range(0, 7));
        for (int p = 0; p < NL; p++) bus.lookup_rs[p*5 +: 5] = 5'($urandom_range(0, 7));
    endtask

    initial begin
        rst = 1'b1;
        bus.lookup_rs = '0;
        d_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst_alloc_tag",   64'(bus.alloc_tag),   64'd0);
        chk("rst_nb_wen",      64'(bus.nb_wen),      64'd0);
        chk("rst_nb_waddr",    64'(bus.nb_waddr),    64'd0);
        chk("rst_nb_wdata",    64'(bus.nb_wdata),    64'd0);
        chk("rst_proto_err",   64'(bus.proto_err),   64'd0);
        chk("rst_busy",        64'(bus.busy),        64'd0);
        chk("rst_lookup_hit",  64'(bus.lookup_hit),  64'd0);
        step();

        // Basic lifecycle: alloc rd5, commit, return.
        d_alloc(5); #2 chk("t1_alloc_tag", 64'(bus.alloc_tag), 64'd0); step();
        d_commit(0); #2 chk("t1_busy", 64'(bus.busy), 64'd1); step();
        d_ret(0, 32'hDEADBEEF); #2;
`ifdef RV_NBLOAD_RET_BYPASS_EN
        chk("t1_byp_wen", 64'(bus.nb_wen), 64'd1);
        chk("t1_byp_waddr", 64'(bus.nb_waddr), 64'd5);
        chk("t1_byp_wdata", 64'(bus.nb_wdata), 64'hDEADBEEF);
        step(); d_idle(); #2;
        chk("t1_after_wen", 64'(bus.nb_wen), 64'd0);
`else
        chk("t1_ret_wen", 64'(bus.nb_wen), 64'd0);
        step(); d_idle(); #2;
        chk("t1_wen", 64'(bus.nb_wen), 64'd1);
        chk("t1_waddr", 64'(bus.nb_waddr), 64'd5);
        chk("t1_wdata", 64'(bus.nb_wdata), 64'hDEADBEEF);
`endif
        step(); d_idle(); #2 chk("t1_busy_end", 64'(bus.busy), 64'd0); step();

        // Fill, overflow, free one.
        for (int i = 0; i < DEPTH; i++) begin
            d_alloc(5'(i + 1)); #2 chk("t2_alloc_tag", 64'(bus.alloc_tag), 64'(i)); step();
        end
        d_alloc(9); #2 chk("t2_full_ready", 64'(bus.alloc_ready), 64'd0); step();
        d_idle(); #2;
        chk("t2_proto_err", 64'(bus.proto_err), 64'd1);
        chk("t2_still_full", 64'(bus.alloc_ready), 64'd0);
        step();
        d_cr(1, 1, 32'h22); step();
        d_idle(); #2;
        chk("t2_wen", 64'(bus.nb_wen), 64'd1);
        chk("t2_waddr", 64'(bus.nb_waddr), 64'd2);
        step();
        d_idle(); #2 chk("t2_freed_tag", 64'(bus.alloc_tag), 64'd1); step();
        d_flush(); step();
        d_idle(); #2 chk("t2_busy_end", 64'(bus.busy), 64'd0); step();

        // Early return then commit; hazard held until the write.
        d_alloc(10); step(); d_alloc(11); step(); d_alloc(12); step();
        bus.lookup_rs[4:0] = 5'd12;
        d_ret(2, 32'h1234); step();
        d_idle(); #2;
        chk("t3_early_wen", 64'(bus.nb_wen), 64'd0);
        chk("t3_early_hit", 64'(bus.lookup_hit[0]), 64'd1);
        step();
        d_commit(2); #2 chk("t3_commit_wen", 64'(bus.nb_wen), 64'd0); step();
        d_idle(); #2;
        chk("t3_wen", 64'(bus.nb_wen), 64'd1);
        chk("t3_waddr", 64'(bus.nb_waddr), 64'd12);
        chk("t3_wdata", 64'(bus.nb_wdata), 64'h1234);
        chk("t3_hit_wb", 64'(bus.lookup_hit[0]), 64'd1);
        step();
        d_idle(); #2 chk("t3_hit_gone", 64'(bus.lookup_hit[0]), 64'd0); step();
        d_flush(); step();

        // Killed committed load drains silently.
        d_alloc(7); step(); d_commit(0); step();
        bus.lookup_rs[4:0] = 5'd7;
        d_idle(); #2 chk("t4_hit", 64'(bus.lookup_hit[0]), 64'd1); step();
        d_kill(7); step();
        d_idle(); #2 chk("t4_hit_killed", 64'(bus.lookup_hit[0]), 64'd0); step();
        d_ret(0, 32'h77); #2 chk("t4_ret_wen", 64'(bus.nb_wen), 64'd0); step();
        d_idle(); #2 chk("t4_wen", 64'(bus.nb_wen), 64'd0); step();
        d_idle(); #2 chk("t4_busy", 64'(bus.busy), 64'd0); step();
        bus.lookup_rs = '0;

        // Flush keeps only the committed entry.
        d_alloc(1); step(); d_alloc(2); step(); d_alloc(3); step();
        d_cr(2, 1, 32'h11); step();
        d_flush(); step();
        d_idle(); #2;
        chk("t5_busy", 64'(bus.busy), 64'd1);
        chk("t5_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        step();
        d_ret(2, 32'h33); #2;
`ifdef RV_NBLOAD_RET_BYPASS_EN
        chk("t5_byp_wen", 64'(bus.nb_wen), 64'd1);
        chk("t5_byp_waddr", 64'(bus.nb_waddr), 64'd3);
        chk("t5_byp_wdata", 64'(bus.nb_wdata), 64'h33);
        step(); d_idle(); #2;
`else
        chk("t5_ret_wen", 64'(bus.nb_wen), 64'd0);
        step(); d_idle(); #2;
        chk("t5_wen", 64'(bus.nb_wen), 64'd1);
        chk("t5_waddr", 64'(bus.nb_waddr), 64'd3);
        chk("t5_wdata", 64'(bus.nb_wdata), 64'h33);
        step(); d_idle(); #2;
`endif
        chk("t5_busy_end", 64'(bus.busy), 64'd0);
        step();

        // Two entries ready together: lower tag wins, other waits a cycle.
        for (int i = 0; i < DEPTH; i++) begin d_alloc(5'(21 + i)); step(); end
        d_ret(1, 32'hA1); step();
        d_commit(3); step();
        d_cr(1, 3, 32'hA3); #2;
`ifdef RV_NBLOAD_RET_BYPASS_EN
        chk("t6_byp_wen", 64'(bus.nb_wen), 64'd1);
        chk("t6_byp_waddr", 64'(bus.nb_waddr), 64'd24);
`else
        chk("t6_n_wen", 64'(bus.nb_wen), 64'd0);
`endif
        step();
        d_idle(); #2;
        chk("t6_n1_waddr", 64'(bus.nb_waddr), 64'd22);
        chk("t6_n1_wdata", 64'(bus.nb_wdata), 64'hA1);
        step();
        d_idle(); #2;
`ifdef RV_NBLOAD_RET_BYPASS_EN
        chk("t6_n2_wen", 64'(bus.nb_wen), 64'd0);
`else
        chk("t6_n2_waddr", 64'(bus.nb_waddr), 64'd24);
        chk("t6_n2_wdata", 64'(bus.nb_wdata), 64'hA3);
`endif
        step();
        d_flush(); step();
        d_idle(); #2 chk("t6_busy_end", 64'(bus.busy), 64'd0); step();

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1'b1;
                d_idle();
                step(); step();
                rst = 1'b0;
                #2;
                chk("mid_rst_busy", 64'(bus.busy), 64'd0);
                chk("mid_rst_wen", 64'(bus.nb_wen), 64'd0);
                step();
            end
            rand_inputs();
            step();
        end
        d_idle();
        bus.lookup_rs = '0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nbload_tracker.md
Name: nbload_tracker

Overview:
Parametrised successor to the fixed non-blocking-load CAM entry (valid/wb/tag/rd).
- Tracks up to DEPTH outstanding non-blocking loads from allocation through commit and data return.
- Holds early-returned data.
- Drives a single registered-state writeback port into the integer register file.
- Reports rd hazards to decode on NUM_LOOKUP source-register ports.
- Sits between the LSU bus interface and the decode/GPR block.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
TAG_W, $clog2(DEPTH), tag width, derived
NUM_LOOKUP, 4, decode rs lookup ports
DATA_W, 32, load data width

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
alloc_valid  in  1  allocate entry for issued nb load
alloc_rd  in  5  destination register
alloc_ready  out  1  at least one IDLE entry
alloc_tag  out  TAG_W  tag granted (lowest-index IDLE)
commit_valid  in  1  load with commit_tag reached writeback
commit_tag  in  TAG_W  tag committing
flush  in  1  pipeline flush; kills uncommitted entries
kill_valid  in  1  younger committed write to kill_rd
kill_rd  in  5  rd overwritten by younger instruction
ret_valid  in  1  load data return
ret_tag  in  TAG_W  returning tag
ret_data  in  DATA_W  returned data
lookup_rs  in  NUM_LOOKUP*5  decode source registers
lookup_hit  out  NUM_LOOKUP  rs matches live, unkilled entry rd (rs!=0)
nb_wen  out  1  GPR write enable
nb_waddr  out  5  GPR write address
nb_wdata  out  DATA_W  GPR write data
proto_err  out  1  one-cycle pulse: illegal commit/ret
busy  out  1  any entry not IDLE

Behaviour:
- Per-entry state machine: IDLE, PEND (allocated), COMMIT (committed, awaiting data), EARLY (data held, not committed), READY (committed with data).
- Per-entry fields: rd[4:0], data[DATA_W-1:0], kill flag.
- Reset: all entries IDLE, kill=0.
  - Outputs after reset: alloc_ready=1, alloc_tag=0, lookup_hit=0, nb_wen=0, nb_waddr=0, nb_wdata=0, proto_err=0, busy=0.
- Transitions:
  - IDLE→PEND on alloc_valid&&alloc_ready at alloc_tag; captures rd, kill=0. alloc_valid with alloc_ready=0 is ignored and raises proto_err.
  - PEND→COMMIT on commit.
  - PEND→EARLY on ret; captures data.
  - PEND→READY on commit and ret in the same cycle.
  - COMMIT→READY on ret.
  - EARLY→READY on commit.
  - READY→IDLE when selected for writeback.
- Writeback:
  - nb_wen/waddr/wdata are combinational from the lowest-index READY entry with kill=0; that entry frees at the clock edge.
  - Every READY entry with kill=1 frees silently in the same cycle.
  - Latency: ret at cycle N on a COMMIT entry gives nb_wen at N+1 if no lower-index READY entry exists.
  - Contention delays the losing entry one cycle per winner.
  - nb_waddr/nb_wdata are 0 when nb_wen=0.
- flush: all PEND and EARLY entries → IDLE. COMMIT and READY are untouched.
  - flush has priority over commit/ret to the same entry in the same cycle, except that commit with ret completes before the flush takes effect.
- kill_valid: sets kill on every COMMIT, EARLY, or READY entry whose rd==kill_rd.
  - kill does not apply to an entry allocated in the same cycle.
- lookup_hit[i]: any non-IDLE, kill=0 entry with rd==lookup_rs[i] and lookup_rs[i]!=0. Combinational.
- Allocation of an entry freed in the same cycle is not permitted; freed entries are allocatable the next cycle.
- proto_err (registered, next cycle) fires on:
  - commit to IDLE/COMMIT/READY;
  - ret to IDLE/EARLY/READY;
  - alloc while full.
  The offending event is otherwise ignored.
- Reset mid-operation: all entries IDLE, held data discarded, no writeback.

Optional Feature:
RV_NBLOAD_RET_BYPASS_EN
- Defined:
  - A ret hitting a COMMIT entry with kill=0 drives the write port in the same cycle: nb_wen=1, nb_waddr=rd, nb_wdata=ret_data. The entry goes directly IDLE.
  - This path has priority over READY entries, which wait.
  - lookup_hit is suppressed for that rd in that cycle.
- Undefined: the path through READY only (latency 1).

Decomposition:
- In swerv_types: new struct nbload_entry_t {state[2:0], kill, rd[4:0], data}.
- In swerv_types: enum nbload_state_t {NB_IDLE, NB_PEND, NB_COMMIT, NB_EARLY, NB_READY}.
- Sub-module nbload_prio_enc: a parametrised lowest-index priority encoder, instantiated twice (free-entry select and READY select).

Test Plan:
- Reset, then alloc rd=5 → tag 0. commit tag 0, then ret tag 0 data 0xDEADBEEF → nb_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after ret. busy=0 after.
- Fill 4 entries → alloc_ready=0. Alloc again → proto_err pulse, no state change. Free one → alloc_tag equals the freed index.
- ret tag 2 data 0x1234 before commit (EARLY) → no write. commit tag 2 → write next cycle. lookup_rs=rd of tag 2 hits until that write.
- Alloc rd=7, commit, then kill_valid kill_rd=7, then ret → no nb_wen. Entry frees. lookup_hit on 7 clears after kill.
- Entries 0 PEND, 1 EARLY, 2 COMMIT; flush → 0 and 1 IDLE. ret tag 2 still writes back.
- Two READY entries in the same cycle (tags 1, 3) → tag 1 written at N+1, tag 3 at N+2. With RV_NBLOAD_RET_BYPASS_EN: ret on a COMMIT entry writes in the same cycle.
